// File: rtl/difftest_commit_queue.sv
// Multi-lane commit capture FIFO feeding the difftest commit, trap and counter ports.
// Accepts up to COMMIT_W retirements per cycle, drains up to COMMIT_W under out_ready, freezes on trap.
module difftest_commit_queue #(
  parameter int         XLEN        = 64,
  parameter int         COMMIT_W    = 2,
  parameter int         DEPTH       = 8,
  parameter logic [6:0] TRAP_OPCODE = 7'h6b
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [COMMIT_W-1:0]        in_valid,
  output logic                       in_ready,
  input  logic [COMMIT_W*XLEN-1:0]   in_pc,
  input  logic [COMMIT_W*32-1:0]     in_inst,
  input  logic [COMMIT_W-1:0]        in_wen,
  input  logic [COMMIT_W*5-1:0]      in_wdest,
  input  logic [COMMIT_W*XLEN-1:0]   in_wdata,
  input  logic [XLEN-1:0]            a0_value,
  input  logic                       out_ready,
  output logic [COMMIT_W-1:0]        out_valid,
  output logic [COMMIT_W*XLEN-1:0]   out_pc,
  output logic [COMMIT_W*32-1:0]     out_inst,
  output logic [COMMIT_W*XLEN-1:0]   out_wdata,
  output logic [COMMIT_W-1:0]        out_wen,
  output logic [COMMIT_W*8-1:0]      out_wdest,
  output logic                       trap,
  output logic [7:0]                 trap_code,
  output logic [XLEN-1:0]            trap_pc,
  output logic [63:0]                cycle_cnt,
  output logic [63:0]                instr_cnt,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   DEPTH_W = DEPTH[CW:0];
  localparam logic [CW-1:0] LANES_W = COMMIT_W[CW-1:0];

  logic [XLEN-1:0] pc_mem_r    [DEPTH];
  logic [31:0]     inst_mem_r  [DEPTH];
  logic            wen_mem_r   [DEPTH];
  logic [4:0]      wdest_mem_r [DEPTH];
  logic [XLEN-1:0] wdata_mem_r [DEPTH];

  logic [CW-1:0]   head_r;
  logic [CW-1:0]   tail_r;
  logic [CW-1:0]   count_r;
  logic            trap_r;

  logic [CW:0]     free_s;
  logic            in_ready_s;
  logic            run_s;
  logic [CW-1:0]   k_s;
  logic [CW-1:0]   enq_s;
  logic [CW-1:0]   p_s;
  logic [CW-1:0]   v_s;
  logic            trap_hit_s;
  logic [XLEN-1:0] trap_pc_s;
  logic            unused_a0_s;

  assign free_s      = DEPTH_W - {1'b0, count_r};
  assign in_ready_s  = !reset && !trap_r && (free_s >= {1'b0, LANES_W});
  assign in_ready    = in_ready_s;
  assign trap        = trap_r;
  assign count       = count_r;
  assign unused_a0_s = ^a0_value[XLEN-1:8];

  // Enqueue/pop sizing and trap search among the popped head entries
  always_comb begin
    k_s        = '0;
    run_s      = 1'b1;
    trap_hit_s = 1'b0;
    trap_pc_s  = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      run_s = run_s & in_valid[i];
      if (run_s) begin
        k_s = k_s + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        k_s = k_s;
      end
    end
    if (in_ready_s) begin
      enq_s = k_s;
    end else begin
      enq_s = '0;
    end
    if (out_ready && !trap_r) begin
      p_s = (count_r < LANES_W) ? count_r : LANES_W;
    end else begin
      p_s = '0;
    end
    v_s = p_s;
    for (int j = 0; j < COMMIT_W; j++) begin
      if (!trap_hit_s && (CW'(j) < p_s) &&
          (inst_mem_r[head_r[AW-1:0] + AW'(j)][6:0] == TRAP_OPCODE)) begin
        trap_hit_s = 1'b1;
        v_s        = CW'(j + 1);
        trap_pc_s  = pc_mem_r[head_r[AW-1:0] + AW'(j)];
      end else begin
        trap_hit_s = trap_hit_s;
      end
    end
  end

  // Entry storage: accepted lanes written in order at the tail
  always_ff @(posedge clock) begin
    for (int i = 0; i < COMMIT_W; i++) begin
      if (CW'(i) < enq_s) begin
        pc_mem_r[tail_r[AW-1:0] + AW'(i)]    <= in_pc[i*XLEN +: XLEN];
        inst_mem_r[tail_r[AW-1:0] + AW'(i)]  <= in_inst[i*32 +: 32];
        wen_mem_r[tail_r[AW-1:0] + AW'(i)]   <= in_wen[i];
        wdest_mem_r[tail_r[AW-1:0] + AW'(i)] <= in_wdest[i*5 +: 5];
        wdata_mem_r[tail_r[AW-1:0] + AW'(i)] <= in_wdata[i*XLEN +: XLEN];
      end
    end
  end

  // Pointers, registered commit lanes, trap capture and counters
  always_ff @(posedge clock) begin
    if (reset) begin
      head_r    <= '0;
      tail_r    <= '0;
      count_r   <= '0;
      trap_r    <= 1'b0;
      trap_code <= 8'h00;
      trap_pc   <= '0;
      cycle_cnt <= 64'd0;
      instr_cnt <= 64'd0;
      out_valid <= '0;
      out_pc    <= '0;
      out_inst  <= '0;
      out_wdata <= '0;
      out_wen   <= '0;
      out_wdest <= '0;
    end else begin
      head_r  <= head_r + p_s;
      tail_r  <= tail_r + enq_s;
      count_r <= count_r + enq_s - p_s;
      if (!trap_r) begin
        cycle_cnt <= cycle_cnt + 64'd1;
        instr_cnt <= instr_cnt + 64'(v_s);
      end
      if (trap_hit_s) begin
        trap_r    <= 1'b1;
        trap_code <= a0_value[7:0];
        trap_pc   <= trap_pc_s;
      end
      for (int j = 0; j < COMMIT_W; j++) begin
        out_valid[j] <= (CW'(j) < v_s);
        if (CW'(j) < p_s) begin
          out_pc[j*XLEN +: XLEN]    <= pc_mem_r[head_r[AW-1:0] + AW'(j)];
          out_inst[j*32 +: 32]      <= inst_mem_r[head_r[AW-1:0] + AW'(j)];
          out_wdata[j*XLEN +: XLEN] <= wdata_mem_r[head_r[AW-1:0] + AW'(j)];
          out_wen[j]                <= wen_mem_r[head_r[AW-1:0] + AW'(j)] &&
                                       (wdest_mem_r[head_r[AW-1:0] + AW'(j)] != 5'd0);
          out_wdest[j*8 +: 8]       <= {3'b000, wdest_mem_r[head_r[AW-1:0] + AW'(j)]};
        end
      end
    end
  end

endmodule

// File: tb/tb_difftest_commit_queue.sv
// Directed self-checking bench for difftest_commit_queue (XLEN=64, COMMIT_W=2, DEPTH=8).
module tb_difftest_commit_queue;

  logic          clock;
  logic          reset;
  logic [1:0]    in_valid;
  logic          in_ready;
  logic [127:0]  in_pc;
  logic [63:0]   in_inst;
  logic [1:0]    in_wen;
  logic [9:0]    in_wdest;
  logic [127:0]  in_wdata;
  logic [63:0]   a0_value;
  logic          out_ready;
  logic [1:0]    out_valid;
  logic [127:0]  out_pc;
  logic [63:0]   out_inst;
  logic [127:0]  out_wdata;
  logic [1:0]    out_wen;
  logic [15:0]   out_wdest;
  logic          trap;
  logic [7:0]    trap_code;
  logic [63:0]   trap_pc;
  logic [63:0]   cycle_cnt;
  logic [63:0]   instr_cnt;
  logic [3:0]    count;

  int            n_checks = 0;
  int            n_pass = 0;
  int            cyc_model = 0;
  logic          model_trap = 1'b0;
  logic [63:0]   frozen_cyc;

  difftest_commit_queue #(.XLEN(64), .COMMIT_W(2), .DEPTH(8), .TRAP_OPCODE(7'h6b)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_wen(in_wen), .in_wdest(in_wdest),
    .in_wdata(in_wdata), .a0_value(a0_value), .out_ready(out_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_wdata(out_wdata),
    .out_wen(out_wen), .out_wdest(out_wdest), .trap(trap), .trap_code(trap_code),
    .trap_pc(trap_pc), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    logic r;
    r = reset;
    @(posedge clock);
    #1;
    if (!r && !model_trap) cyc_model++;
  endtask

  task automatic push2(input logic [63:0] base);
    in_valid = 2'b11;
    in_pc    = {base + 64'd4, base};
    in_inst  = {32'h0000_0013, 32'h0000_0013};
    in_wen   = 2'b11;
    in_wdest = {5'd0, 5'd5};
    in_wdata = {base ^ 64'h55, base ^ 64'haa};
  endtask

  initial begin
    reset = 1'b1; in_valid = 2'b00; in_pc = '0; in_inst = '0; in_wen = '0;
    in_wdest = '0; in_wdata = '0; a0_value = 64'd0; out_ready = 1'b1;
    #1;
    tick; tick;
    check("rst_in_ready", in_ready, 0);
    check("rst_count", count, 0);
    check("rst_cycle", cycle_cnt, 0);
    check("rst_out_valid", out_valid, 0);
    reset = 1'b0; cyc_model = 0;
    #1;
    check("idle_in_ready", in_ready, 1);
    tick; tick; tick;
    check("idle_cycle", cycle_cnt, 3);
    check("idle_out_valid", out_valid, 0);

    // Two-lane commit, visible after the second edge
    push2(64'h8000_0000);
    tick;
    check("c2_count", count, 2);
    check("c2_valid_early", out_valid, 0);
    in_valid = 2'b00;
    tick;
    check("c2_valid", out_valid, 2'b11);
    check("c2_pc0", out_pc[63:0], 64'h8000_0000);
    check("c2_pc1", out_pc[127:64], 64'h8000_0004);
    check("c2_inst1", out_inst[63:32], 32'h0000_0013);
    check("c2_wdata0", out_wdata[63:0], 64'h8000_00aa);
    check("c2_wen", out_wen, 2'b01);
    check("c2_wdest", out_wdest, 16'h0005);
    check("c2_instr", instr_cnt, 2);
    tick;
    check("c2_empty_valid", out_valid, 0);

    // Non-contiguous valid is rejected
    push2(64'h9000_0000);
    in_valid = 2'b10;
    tick;
    check("nc_count", count, 0);
    in_valid = 2'b00;
    tick;
    check("nc_valid", out_valid, 0);
    check("nc_instr", instr_cnt, 2);

    // Fill to full with draining stalled, then drain across the wrap
    out_ready = 1'b0;
    for (int n = 0; n < 4; n++) begin
      push2(64'h1000 + 64'(8 * n));
      tick;
      if (n == 2) begin
        check("fill_count6", count, 6);
        check("fill_ready6", in_ready, 1);
      end
    end
    check("fill_count8", count, 8);
    check("fill_ready8", in_ready, 0);
    push2(64'hdead_0000);
    tick;
    check("full_reject", count, 8);
    in_valid = 2'b00;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick;
      check("drain_valid", out_valid, 2'b11);
      check("drain_pc0", out_pc[63:0], 64'h1000 + 64'(8 * c));
      check("drain_pc1", out_pc[127:64], 64'h1004 + 64'(8 * c));
    end
    check("drain_count", count, 0);
    check("drain_instr", instr_cnt, 10);
    tick;
    check("drain_idle", out_valid, 0);

    // Same-cycle enqueue and pop
    push2(64'h2000);
    tick;
    push2(64'h2008);
    tick;
    check("sim_count", count, 2);
    check("sim_pc0", out_pc[63:0], 64'h2000);
    in_valid = 2'b00;
    tick;
    check("sim_pc1", out_pc[127:64], 64'h200c);
    check("sim_count0", count, 0);
    check("sim_instr", instr_cnt, 14);

    // Trap in lane 0 with lane 1 valid; seven entries queued
    out_ready = 1'b0;
    push2(64'h3000);
    in_inst[31:0] = 32'h0000_006b;
    tick;
    push2(64'h3008); tick;
    push2(64'h3010); tick;
    push2(64'h3018); in_valid = 2'b01; tick;
    check("tq_count", count, 7);
    in_valid = 2'b00;
    a0_value = 64'h0000_0000_0000_ab00;
    out_ready = 1'b1;
    tick;
    model_trap = 1'b1;
    check("trap_flag", trap, 1);
    check("trap_code", trap_code, 8'h00);
    check("trap_pc", trap_pc, 64'h3000);
    check("trap_valid", out_valid, 2'b01);
    check("trap_instr", instr_cnt, 15);
    check("trap_cycle", cycle_cnt, 64'(cyc_model));
    check("trap_count", count, 5);
    frozen_cyc = cycle_cnt;
    push2(64'h5000);
    for (int c = 0; c < 10; c++) tick;
    check("frz_ready", in_ready, 0);
    check("frz_count", count, 5);
    check("frz_cycle", cycle_cnt, frozen_cyc);
    check("frz_instr", instr_cnt, 15);
    check("frz_valid", out_valid, 0);

    // Reset with trap pending and entries queued
    reset = 1'b1;
    tick;
    check("r2_ready", in_ready, 0);
    check("r2_trap", trap, 0);
    check("r2_code", trap_code, 0);
    check("r2_tpc", trap_pc, 0);
    check("r2_count", count, 0);
    check("r2_cycle", cycle_cnt, 0);
    check("r2_instr", instr_cnt, 0);
    check("r2_valid", out_valid, 0);
    check("r2_pc", out_pc[63:0], 0);
    check("r2_wen", out_wen, 0);
    reset = 1'b0; model_trap = 1'b0; cyc_model = 0;
    push2(64'h4000);
    tick;
    check("r2_enq", count, 2);
    in_valid = 2'b00;
    tick;
    check("r2_out_valid", out_valid, 2'b11);
    check("r2_out_pc", out_pc[63:0], 64'h4000);
    check("r2_out_instr", instr_cnt, 2);
    check("r2_out_cycle", cycle_cnt, 64'(cyc_model));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/difftest_commit_queue.md
# difftest_commit_queue

Parametrised, multi-lane commit capture buffer between the CPU writeback stage and the difftest commit/trap/counter ports of the simulation top. Each cycle it accepts up to COMMIT_W retired instructions, queues them in order in a DEPTH-entry FIFO, and drains up to COMMIT_W per cycle into registered per-lane commit outputs. Draining is under a throttle input. It also detects the trap instruction, latches trap code and PC, freezes on trap, and keeps cycle and instruction counters.

## Interface
- XLEN, 64, data/PC width
- COMMIT_W, 2, commit lanes in and out (1..4)
- DEPTH, 8, FIFO entries; power of two, ≥ 2*COMMIT_W
- TRAP_OPCODE, 7'h6b, inst[6:0] value that ends simulation

Reset is synchronous and active-high on `reset`; one clock, `clock`.
- clock  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  COMMIT_W  per-lane commit valid, lane 0 oldest
- in_ready  out  1  = !reset & !trap & (DEPTH − count ≥ COMMIT_W)
- in_pc  in  COMMIT_W*XLEN  lane i at [i*XLEN +: XLEN]
- in_inst  in  COMMIT_W*32  instruction word per lane
- in_wen  in  COMMIT_W  register write enable per lane
- in_wdest  in  COMMIT_W*5  destination register per lane
- in_wdata  in  COMMIT_W*XLEN  write data per lane
- a0_value  in  XLEN  current x10, source of trap code
- out_ready  in  1  drain enable from difftest side
- out_valid  out  COMMIT_W  registered commit valid per lane
- out_pc / out_inst / out_wdata  out  COMMIT_W*XLEN / COMMIT_W*32 / COMMIT_W*XLEN  registered commit fields
- out_wen  out  COMMIT_W  = stored wen & (wdest ≠ 0)
- out_wdest  out  COMMIT_W*8  {3'b0, wdest}
- trap  out  1  sticky trap flag
- trap_code  out  8  a0_value[7:0] at trap capture
- trap_pc  out  XLEN  PC of trapping instruction
- cycle_cnt  out  64  cycles since reset, frozen on trap
- instr_cnt  out  64  committed instructions, frozen on trap
- count  out  log2(DEPTH)+1  current FIFO occupancy

## Operation
- Enqueue: when in_ready, take lanes 0..k−1, where k = number of contiguous set in_valid bits starting at lane 0. Lanes after the first clear bit are dropped. Entries are written in lane order at tail. in_ready low means nothing is accepted.
- Pointers are log2(DEPTH)+1 bits with a wrap bit. full = (count == DEPTH), empty = (count == 0). Enqueue and pop in the same cycle are allowed. Count updates by (+k − p).
- Drain: each edge with out_ready=1 and !trap, pop p = min(count, COMMIT_W) head entries into out lanes 0..p−1. out_valid[j] is set for j<p and cleared otherwise.
- out_ready=0 or empty: out_valid is cleared next edge. Other out fields hold.
- Trap: if a popped entry in lane j has inst[6:0]==TRAP_OPCODE, the following happen at the same edge:
  - trap←1, trap_code←a0_value[7:0], trap_pc←that PC.
  - out lanes >j get out_valid=0; those entries are discarded.
- After trap: no pops, no enqueues, counters frozen, out_valid cleared on the next edge. Only reset clears trap.
- cycle_cnt increments by 1 every edge with !reset & !trap, including the trapping edge.
- instr_cnt increments by the number of out_valid lanes set at that edge; the trapping instruction is counted.

## Timing
- Reset (synchronous): pointers, count, out_valid, out_wen, all out fields, trap, trap_code, trap_pc, cycle_cnt and instr_cnt are 0. in_ready=0 while reset is high.
- Reset asserted mid-operation discards the FIFO contents and any pending trap, with no partial drain.
- Latency: an entry written at edge N can appear on out_* no earlier than after edge N+1. It is held exactly one cycle per pop.
- in_ready is combinational from registered count and trap. It does not credit a same-cycle pop.
- Throughput: sustains COMMIT_W commits per cycle with out_ready=1 continuously.

## Test plan
- Reset, then idle with out_ready=1 → in_ready=1, count=0, out_valid=0, and cycle_cnt increments by 1 per cycle.
- COMMIT_W=2: in_valid=2'b11 with PCs 0x80000000 and 0x80000004 for one cycle → out_valid=2'b11 after the second edge with those PCs in lanes 0 and 1; instr_cnt=2.
- in_valid=2'b10 (non-contiguous) → nothing is accepted, count remains 0.
- out_ready=0, and 3 cycles of 2 commits each → count=6, in_ready=1. A 4th cycle of 2 commits gives count=8 and in_ready=0. Raising out_ready drains 2 per cycle in PC order, with the wrap-around crossing verified.
- Lane 0 trap instruction 0x0000006b with a0_value=0x0 and lane 1 valid → trap=1, trap_code=0x00, trap_pc=lane-0 PC, out_valid=2'b01, instr_cnt +1. Afterwards in_ready=0 and both counters stay constant for 10 cycles.
- Reset pulsed while count=5 and trap=1 → all outputs return to 0, and enqueue resumes normally on the next cycle.
